// File: rtl/store_issue_if.sv
// Store issue port bundle: CPU store request handshake on one side, memory
// write port and completion/status signals on the other.
// master: the store issue unit. slave: the surrounding pipeline/memory.
interface store_issue_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic [2:0]  bytes_to_write;
    logic [31:0] write_addr;
    logic [31:0] write_data;
    logic        write_data_valid;
    logic        write_done;
    logic        store_done;
    logic        store_fault;
    logic        busy;

    modport master (
        input  req_valid, req_addr, req_data, req_size, write_done,
        output req_ready, bytes_to_write, write_addr, write_data,
               write_data_valid, store_done, store_fault, busy
    );

    modport slave (
        output req_valid, req_addr, req_data, req_size, write_done,
        input  req_ready, bytes_to_write, write_addr, write_data,
               write_data_valid, store_done, store_fault, busy
    );
endinterface

// File: rtl/store_issue_unit.sv
// Store issue unit: buffers CPU stores in a DEPTH-entry FIFO and issues them
// one at a time on the memory write port, holding each write until
// write_done and leaving one idle cycle between writes so no write repeats.
// Optional feature macro: STORE_ALIGN_CHECK_EN -- when defined, misaligned
// stores are dropped without a memory write and reported on store_fault.
module store_issue_unit #(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    store_issue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t      state;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [31:0] addr_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];
    logic [1:0]  size_mem [DEPTH];
    logic        full;
    logic        empty;
    logic        push;
    logic [31:0] head_addr;
    logic [31:0] head_data;
    logic [1:0]  head_size;

    // Request size code to byte count; codes 2 and 3 are both a word.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        case (size)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

`ifdef STORE_ALIGN_CHECK_EN
    // Halves must be 2-byte aligned, words 4-byte aligned; bytes never fault.
    function automatic logic misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return addr_lo[0];
            default: return (addr_lo != 2'd0);
        endcase
    endfunction
`endif

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign push  = bus.req_valid && !full;

    assign head_addr = addr_mem[rd_ptr[AW-1:0]];
    assign head_data = data_mem[rd_ptr[AW-1:0]];
    assign head_size = size_mem[rd_ptr[AW-1:0]];

    // Ready depends only on registered pointers, so a same-cycle pop never opens a full FIFO.
    assign bus.req_ready = !full;
    assign bus.busy      = !empty || (state == ISSUE);

`ifndef STORE_ALIGN_CHECK_EN
    assign bus.store_fault = 1'b0;
`endif

    // FIFO storage write; contents need no reset because pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr[AW-1:0]] <= bus.req_addr;
            data_mem[wr_ptr[AW-1:0]] <= bus.req_data;
            size_mem[wr_ptr[AW-1:0]] <= bus.req_size;
        end
    end

    // Write pointer advances on every accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    // Issue FSM: owns the read pointer and all registered write-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            rd_ptr               <= '0;
            bus.bytes_to_write   <= 3'd0;
            bus.write_addr       <= 32'd0;
            bus.write_data       <= 32'd0;
            bus.write_data_valid <= 1'b0;
            bus.store_done       <= 1'b0;
`ifdef STORE_ALIGN_CHECK_EN
            bus.store_fault      <= 1'b0;
`endif
        end else begin
            bus.store_done  <= 1'b0;
`ifdef STORE_ALIGN_CHECK_EN
            bus.store_fault <= 1'b0;
`endif
            case (state)
                IDLE, GAP: begin
                    if (!empty) begin
`ifdef STORE_ALIGN_CHECK_EN
                        if (misaligned(head_addr[1:0], head_size)) begin
                            rd_ptr          <= rd_ptr + PTR_ONE;
                            bus.store_done  <= 1'b1;
                            bus.store_fault <= 1'b1;
                            state           <= IDLE;
                        end else
`endif
                        begin
                            bus.bytes_to_write   <= size_to_bytes(head_size);
                            bus.write_addr       <= head_addr;
                            bus.write_data       <= head_data;
                            bus.write_data_valid <= 1'b1;
                            state                <= ISSUE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    if (bus.write_done) begin
                        bus.write_data_valid <= 1'b0;
                        bus.bytes_to_write   <= 3'd0;
                        rd_ptr               <= rd_ptr + PTR_ONE;
                        bus.store_done       <= 1'b1;
                        state                <= GAP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_store_issue_unit.sv
// Directed bench for store_issue_unit with a byte-addressed memory model.
module tb_store_issue_unit;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_cnt = 0;
    int   base;
    logic [7:0] mem [0:1023];

    store_issue_if bus();

    store_issue_unit #(.DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Count store_done pulses using the value seen just before each rising edge.
    always @(posedge clk) begin
        if (bus.store_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
    endfunction

    task automatic apply_write();
        logic [31:0] a;
        for (int i = 0; i < int'(bus.bytes_to_write); i++) begin
            a = bus.write_addr + 32'(i);
            mem[a[9:0]] = bus.write_data[8*i +: 8];
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        int t = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_data  = data;
        bus.req_size  = size;
        while (!bus.req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("push_ready_timeout", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Waits for an issued write, checks it, stalls, then completes it.
    task automatic serve(input int stall, input logic [2:0] eb, input logic [31:0] ea, input logic [31:0] ed);
        int t = 0;
        while (!bus.write_data_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("issue_valid", 32'(bus.write_data_valid), 32'd1);
        check("issue_bytes", 32'(bus.bytes_to_write), 32'(eb));
        check("issue_addr", bus.write_addr, ea);
        check("issue_data", bus.write_data, ed);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.write_data_valid), 32'd1);
            check("hold_addr", bus.write_addr, ea);
        end
        apply_write();
        bus.write_done = 1'b1;
        @(negedge clk);
        bus.write_done = 1'b0;
        check("drop_valid", 32'(bus.write_data_valid), 32'd0);
        check("drop_bytes", 32'(bus.bytes_to_write), 32'd0);
        check("store_done_pulse", 32'(bus.store_done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        bus.req_valid  = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_data   = 32'd0;
        bus.req_size   = 2'd0;
        bus.write_done = 1'b0;

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        check("rst_valid", 32'(bus.write_data_valid), 32'd0);
        check("rst_bytes", 32'(bus.bytes_to_write), 32'd0);
        check("rst_addr", bus.write_addr, 32'd0);
        check("rst_data", bus.write_data, 32'd0);
        check("rst_done", 32'(bus.store_done), 32'd0);
        check("rst_fault", 32'(bus.store_fault), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'd1);

        // Word store with latency and stall
        base = done_cnt;
        push(32'h100, 32'hffff_ffff, 2'd2);
        check("lat_valid_low", 32'(bus.write_data_valid), 32'd0);
        check("lat_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("lat_valid_high", 32'(bus.write_data_valid), 32'd1);
        serve(2, 3'd4, 32'h100, 32'hffff_ffff);
        @(negedge clk);
        check("word_done_once", 32'(done_cnt - base), 32'd1);
        check("word_done_low", 32'(bus.store_done), 32'd0);
        check("word_idle_busy", 32'(bus.busy), 32'd0);
        check("word_mem", mem_word(10'h100), 32'hffff_ffff);

        // Byte then half
        push(32'h100, 32'h0000_0000, 2'd0);
        serve(0, 3'd1, 32'h100, 32'h0000_0000);
        @(negedge clk);
        check("byte_mem", mem_word(10'h100), 32'hffff_ff00);
        push(32'h100, 32'h0000_0000, 2'd1);
        serve(0, 3'd2, 32'h100, 32'h0000_0000);
        @(negedge clk);
        check("half_mem", mem_word(10'h100), 32'hffff_0000);

        // Fill FIFO while memory stalls; in-order retirement, one-cycle gap
        base = done_cnt;
        push(32'h104, 32'hdead_beef, 2'd2);
        push(32'h104, 32'hb0ba_cafe, 2'd1);
        check("full_ready", 32'(bus.req_ready), 32'd0);
        check("full_busy", 32'(bus.busy), 32'd1);
        serve(3, 3'd4, 32'h104, 32'hdead_beef);
        @(negedge clk);
        check("gap_one_cycle", 32'(bus.write_data_valid), 32'd1);
        serve(1, 3'd2, 32'h104, 32'hb0ba_cafe);
        @(negedge clk);
        check("fill_mem", mem_word(10'h104), 32'hdead_cafe);
        check("fill_done_cnt", 32'(done_cnt - base), 32'd2);
        check("fill_idle_busy", 32'(bus.busy), 32'd0);

        // Unaligned word over zeroed memory
        for (int i = 'h100; i < 'h108; i++) mem[i] = 8'h00;
        base = done_cnt;
        push(32'h101, 32'haabb_ccdd, 2'd2);
`ifdef STORE_ALIGN_CHECK_EN
        @(negedge clk);
        check("unal_fault", 32'(bus.store_fault), 32'd1);
        check("unal_done", 32'(bus.store_done), 32'd1);
        check("unal_no_valid", 32'(bus.write_data_valid), 32'd0);
        @(negedge clk);
        check("unal_fault_low", 32'(bus.store_fault), 32'd0);
        check("unal_busy", 32'(bus.busy), 32'd0);
        check("unal_mem", mem_word(10'h100), 32'h0000_0000);
        check("unal_done_cnt", 32'(done_cnt - base), 32'd1);
`else
        serve(0, 3'd4, 32'h101, 32'haabb_ccdd);
        check("unal_fault", 32'(bus.store_fault), 32'd0);
        @(negedge clk);
        check("unal_mem", mem_word(10'h100), 32'hbbcc_dd00);
        check("unal_done_cnt", 32'(done_cnt - base), 32'd1);
`endif

        // write_done held across two edges retires only the store in ISSUE
        base = done_cnt;
        push(32'h300, 32'h1111_1111, 2'd2);
        push(32'h304, 32'h2222_2222, 2'd2);
        check("hold_first_valid", 32'(bus.write_data_valid), 32'd1);
        apply_write();
        bus.write_done = 1'b1;
        @(negedge clk);
        check("hold_gap_valid", 32'(bus.write_data_valid), 32'd0);
        check("hold_gap_done", 32'(bus.store_done), 32'd1);
        @(negedge clk);
        bus.write_done = 1'b0;
        check("hold_next_valid", 32'(bus.write_data_valid), 32'd1);
        check("hold_next_addr", bus.write_addr, 32'h304);
        check("hold_no_extra_done", 32'(bus.store_done), 32'd0);
        serve(0, 3'd4, 32'h304, 32'h2222_2222);
        @(negedge clk);
        check("hold_done_cnt", 32'(done_cnt - base), 32'd2);
        check("hold_mem", mem_word(10'h304), 32'h2222_2222);

        // Reset during ISSUE
        push(32'h200, 32'h1234_5678, 2'd2);
        @(negedge clk);
        check("mid_valid_before", 32'(bus.write_data_valid), 32'd1);
        base = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("mid_valid_drop", 32'(bus.write_data_valid), 32'd0);
        check("mid_busy", 32'(bus.busy), 32'd0);
        check("mid_bytes", 32'(bus.bytes_to_write), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_no_done", 32'(done_cnt - base), 32'd0);
        check("mid_idle_valid", 32'(bus.write_data_valid), 32'd0);
        check("mid_ready", 32'(bus.req_ready), 32'd1);
        push(32'h200, 32'h0bad_f00d, 2'd2);
        serve(0, 3'd4, 32'h200, 32'h0bad_f00d);
        @(negedge clk);
        check("mid_after_mem", mem_word(10'h200), 32'h0bad_f00d);

        // write_done while idle
        base = done_cnt;
        bus.write_done = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("idle_wd_done", 32'(bus.store_done), 32'd0);
            check("idle_wd_busy", 32'(bus.busy), 32'd0);
        end
        bus.write_done = 1'b0;
        @(negedge clk);
        check("idle_wd_cnt", 32'(done_cnt - base), 32'd0);
        check("idle_wd_ready", 32'(bus.req_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
